// File: rtl/dram16_fifo_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : dram16_fifo_ctrl_pkg
// Desc    : Shared sizes and output-stage state encoding for the 16-deep
//           distributed-RAM FIFO.
// Rev     : 1.0 - initial release
// ============================================================================
package dram16_fifo_ctrl_pkg;

    localparam int DRAM16_DEPTH   = 16;
    localparam int DRAM16_PTR_W   = 4;
    localparam int DRAM16_LEVEL_W = 5;

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_HOLD  = 1'b1
    } out_state_t;

endpackage : dram16_fifo_ctrl_pkg
`default_nettype wire

// File: rtl/dram16_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : dram16_fifo_ctrl_if
// Desc      : Push side, valid/ready read side and status of the DVI FIFO.
// Rev       : 1.0 - initial release
// ============================================================================
interface dram16_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 20
);
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  WR_EN;
    logic                  FULL;
    logic                  AFULL;
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_VALID;
    logic                  RD_READY;
    logic [4:0]            LEVEL;
    logic                  OVF;
    logic                  UDF;

    // FIFO side
    modport slave (
        input  WR_DATA, WR_EN, RD_READY,
        output FULL, AFULL, RD_DATA, RD_VALID, LEVEL, OVF, UDF
    );

    // Producer / consumer side
    modport master (
        output WR_DATA, WR_EN, RD_READY,
        input  FULL, AFULL, RD_DATA, RD_VALID, LEVEL, OVF, UDF
    );
endinterface : dram16_fifo_ctrl_if
`default_nettype wire

// File: rtl/dram16_storage.sv
`default_nettype none
// ============================================================================
// Module : dram16_storage
// Desc   : 16 x DATA_WIDTH array, synchronous write / asynchronous read, so it
//          maps onto distributed (LUT) RAM. Contents are not reset.
// Rev    : 1.0 - initial release
// ============================================================================
module dram16_storage
    import dram16_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 20
) (
    input  logic                    clk,
    input  logic                    i_wr_en,
    input  logic [DRAM16_PTR_W-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_wr_data,
    input  logic [DRAM16_PTR_W-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0]   o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DRAM16_DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule : dram16_storage
`default_nettype wire

// File: rtl/dram16_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module : dram16_fifo_ctrl
// Desc   : 16-entry FWFT FIFO controller with registered valid/ready read port.
//          Define DRAM16_FIFO_ERR_EN to enable sticky OVF/UDF error flags.
// Rev    : 1.0 - initial release
// ============================================================================
module dram16_fifo_ctrl
    import dram16_fifo_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH  = 20,
    parameter int AFULL_LEVEL = 12
) (
    input  logic              CLK,
    input  logic              RST,
    dram16_fifo_ctrl_if.slave bus
);

    localparam logic [DRAM16_LEVEL_W-1:0] c_full_count  = DRAM16_LEVEL_W'(DRAM16_DEPTH);
    localparam logic [DRAM16_LEVEL_W-1:0] c_afull_count = DRAM16_LEVEL_W'(AFULL_LEVEL);
    localparam logic [DRAM16_LEVEL_W-1:0] c_count_one   = DRAM16_LEVEL_W'(1);
    localparam logic [DRAM16_PTR_W-1:0]   c_ptr_one     = DRAM16_PTR_W'(1);

    out_state_t                  r_state;
    out_state_t                  w_state_nxt;
    logic [DRAM16_PTR_W-1:0]     r_wr_ptr;
    logic [DRAM16_PTR_W-1:0]     r_rd_ptr;
    logic [DRAM16_LEVEL_W-1:0]   r_count;
    logic [DATA_WIDTH-1:0]       r_rd_data;
    logic [DATA_WIDTH-1:0]       w_ram_rd_data;
    logic                        w_full;
    logic                        w_ram_empty;
    logic                        w_push;
    logic                        w_load;

    // Status is decoded straight from the count register, so it only moves on edges.
    assign w_full      = (r_count == c_full_count);
    assign w_ram_empty = (r_count == '0);
    assign w_push      = bus.WR_EN & ~w_full;

    dram16_storage #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_storage (
        .clk       (CLK),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (bus.WR_DATA),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_ram_rd_data)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (!w_ram_empty) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.RD_READY) begin
                    if (!w_ram_empty) begin
                        w_load = 1'b1;
                    end else begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_rd_data <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_load) begin
                r_rd_ptr  <= r_rd_ptr + c_ptr_one;
                r_rd_data <= w_ram_rd_data;
            end
            // A load and an accepted push in the same cycle cancel out.
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + c_count_one;
                2'b01:   r_count <= r_count - c_count_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef DRAM16_FIFO_ERR_EN
    logic r_ovf;
    logic r_udf;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            if (bus.WR_EN && w_full) begin
                r_ovf <= 1'b1;
            end
            if (bus.RD_READY && (r_state == ST_EMPTY)) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign bus.OVF = r_ovf;
    assign bus.UDF = r_udf;
`else
    assign bus.OVF = 1'b0;
    assign bus.UDF = 1'b0;
`endif

    assign bus.FULL     = w_full;
    assign bus.AFULL    = (r_count >= c_afull_count);
    assign bus.LEVEL    = r_count;
    assign bus.RD_DATA  = r_rd_data;
    assign bus.RD_VALID = (r_state == ST_HOLD);

endmodule : dram16_fifo_ctrl
`default_nettype wire
